dcache_mem_port: RTL and testbench

Memory-side initiator for the data cache. Accepts one line-miss at a time from the cache controller, optionally writes back a dirty 128-bit victim line, then issues the refill read over the `mem_req`/`mem_data` interface and returns the line to the cache. Sits between the data cache controller and the data memory model, driving the request side of that interface. Adds a response timeout, exception abort and event counters.

---
 rtl/dcache_mem_port_if.sv | 19 +
 rtl/dcache_mem_port.sv | 77 +++++++
 tb/tb_dcache_mem_port.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_mem_port_if.sv
// dcache_mem_port_if: request/response bus between the data-cache memory port and the memory model.
typedef struct packed {
  logic         valid;
  logic         rw;
  logic [31:0]  addr;
  logic [127:0] data;
} mem_req_type;

typedef struct packed {
  logic [127:0] data;
  logic         ready;
} mem_data_type;

interface dcache_mem_port_if;
  mem_req_type  mem_req;
  mem_data_type mem_data;
  modport master(output mem_req, input mem_data);
  modport slave(input mem_req, output mem_data);
endinterface

// File: rtl/dcache_mem_port.sv
// dcache_mem_port: one miss at a time, optional dirty-victim writeback, then refill read with timeout and abort.
module dcache_mem_port #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 miss_valid,
  output logic                 miss_ready,
  input  logic [31:0]          miss_addr,
  input  logic                 victim_dirty,
  input  logic [31:0]          victim_addr,
  input  logic [127:0]         victim_data,
  output logic                 fill_valid,
  output logic [31:0]          fill_addr,
  output logic [127:0]         fill_data,
  dcache_mem_port_if.master    mem,
  input  logic [2:0]           excpt_in,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     wb_count,
  output logic [CNT_W-1:0]     fill_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, WB, GAP, FILL, RESP} state_t;
  state_t state, state_nx;
  logic [TW-1:0] timer;
  logic [31:0] line_addr;
  logic ready, abort, busy, expire, accept;
  assign ready = mem.mem_data.ready;
  assign abort = |excpt_in;
  assign busy = state == WB || state == FILL;
  assign expire = busy && !ready && !abort && timer == TW'(TIMEOUT_CYCLES - 1);
  assign accept = state == IDLE && miss_valid && !abort;
  assign miss_ready = state == IDLE && reset;
  always_comb begin
    state_nx = state;
    if (abort || expire) state_nx = IDLE;
    else case (state)
      IDLE: if (miss_valid) state_nx = victim_dirty ? WB : FILL;
      WB: if (ready) state_nx = GAP;
      GAP: state_nx = FILL;
      FILL: if (ready) state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      timer <= '0;
      line_addr <= '0;
      mem.mem_req <= '0;
      fill_valid <= 1'b0;
      fill_addr <= '0;
      fill_data <= '0;
      timeout_err <= 1'b0;
      wb_count <= '0;
      fill_count <= '0;
    end else begin
      state <= state_nx;
      timer <= (busy && state_nx == state) ? timer + TW'(1) : '0;
      fill_valid <= state_nx == RESP;
      if (state_nx == RESP) begin
        fill_addr <= line_addr;
        fill_data <= mem.mem_data.data;
      end
      if (expire) timeout_err <= 1'b1;
      if (state == WB && state_nx == GAP && wb_count != '1) wb_count <= wb_count + CNT_W'(1);
      if (state_nx == RESP && fill_count != '1) fill_count <= fill_count + CNT_W'(1);
      // request fields are loaded once per transaction and held until the state is left
      if (accept) begin
        line_addr <= miss_addr & 32'hFFFF_FFF0;
        mem.mem_req <= victim_dirty ? {1'b1, 1'b1, victim_addr & 32'hFFFF_FFF0, victim_data}
                                    : {1'b1, 1'b0, miss_addr & 32'hFFFF_FFF0, 128'd0};
      end else if (state == GAP && state_nx == FILL) mem.mem_req <= {1'b1, 1'b0, line_addr, 128'd0};
      else if (state_nx != state) mem.mem_req <= '0;
    end
endmodule

// File: tb/tb_dcache_mem_port.sv
// tb_dcache_mem_port: randomized misses against a line-level memory model with a queued fill scoreboard.
module tb_dcache_mem_port;
  logic clock = 1'b0, reset = 1'b0;
  always #5 clock = ~clock;

  logic miss_valid = 1'b0, victim_dirty = 1'b0;
  logic [31:0] miss_addr = '0, victim_addr = '0;
  logic [127:0] victim_data = '0;
  logic [2:0] excpt_in = '0;
  logic miss_ready, miss_ready2, fill_valid, fill_valid2, timeout_err, timeout_err2;
  logic [31:0] fill_addr, fill_addr2;
  logic [127:0] fill_data, fill_data2;
  logic [15:0] wb_count, fill_count;
  logic [3:0] wb_count2, fill_count2;

  dcache_mem_port_if mif();
  dcache_mem_port_if mif2();
  assign mif2.mem_data = mif.mem_data;

  dcache_mem_port dut (
    .clock(clock), .reset(reset), .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_addr(miss_addr), .victim_dirty(victim_dirty), .victim_addr(victim_addr),
    .victim_data(victim_data), .fill_valid(fill_valid), .fill_addr(fill_addr),
    .fill_data(fill_data), .mem(mif.master), .excpt_in(excpt_in), .timeout_err(timeout_err),
    .wb_count(wb_count), .fill_count(fill_count));

  // narrow-counter twin follows the same traffic so saturation is reachable quickly
  dcache_mem_port #(.CNT_W(4)) dut2 (
    .clock(clock), .reset(reset), .miss_valid(miss_valid), .miss_ready(miss_ready2),
    .miss_addr(miss_addr), .victim_dirty(victim_dirty), .victim_addr(victim_addr),
    .victim_data(victim_data), .fill_valid(fill_valid2), .fill_addr(fill_addr2),
    .fill_data(fill_data2), .mem(mif2.master), .excpt_in(excpt_in), .timeout_err(timeout_err2),
    .wb_count(wb_count2), .fill_count(fill_count2));

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    int           due;
  } exp_t;
  exp_t sbq[$];

  logic [127:0] mem [4096];
  logic [127:0] ref_mem [4096];
  int lat = 7, wcnt = 0, cyc = 0, n_wb = 0, n_fill = 0;
  int checks = 0, passed = 0;
  bit hang = 1'b0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic int sat(int n, int m);
    return n > m ? m : n;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // memory responder: ready after lat cycles of valid, random data whenever not serving a read
  always @(negedge clock) begin
    wcnt = mif.mem_req.valid ? wcnt + 1 : 0;
    mif.mem_data.ready = !hang && mif.mem_req.valid && wcnt >= lat;
    mif.mem_data.data = (mif.mem_req.valid && !mif.mem_req.rw) ? mem[mif.mem_req.addr[15:4]]
                                                               : {$urandom, $urandom, $urandom, $urandom};
  end

  always @(posedge clock)
    if (reset && excpt_in == 3'd0 && mif.mem_req.valid && mif.mem_req.rw && mif.mem_data.ready)
      mem[mif.mem_req.addr[15:4]] <= mif.mem_req.data;

  always @(negedge clock)
    if (reset && fill_valid) begin
      if (sbq.size() == 0) chk("unexpected_fill", 128'(fill_valid), 128'(0));
      else begin : pop
        exp_t e;
        e = sbq.pop_front();
        chk("fill_addr", 128'(fill_addr), 128'(e.addr));
        chk("fill_data", fill_data, e.data);
        chk("fill_due_cycle", 128'(cyc), 128'(e.due));
        chk("fill_valid_small", 128'(fill_valid2), 128'(1));
        chk("fill_data_small", fill_data2, e.data);
      end
    end

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (!miss_ready && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (!miss_ready) chk("idle_wait", 128'(miss_ready), 128'(1));
  endtask

  task automatic issue(input logic [31:0] ma, input bit d, input logic [31:0] va,
                       input logic [127:0] vd, output int c0);
    miss_addr = ma; victim_dirty = d; victim_addr = va; victim_data = vd; miss_valid = 1'b1;
    @(posedge clock);
    #1;
    c0 = cyc;
    miss_valid = 1'b0; miss_addr = $urandom; victim_addr = $urandom; victim_dirty = 1'($urandom);
  endtask

  task automatic start_miss(input logic [31:0] ma, input bit d, input logic [31:0] va,
                            input logic [127:0] vd);
    exp_t e;
    int c0;
    if (d) ref_mem[va[15:4]] = vd;
    e.addr = ma & 32'hFFFF_FFF0;
    e.data = ref_mem[ma[15:4]];
    issue(ma, d, va, vd, c0);
    e.due = c0 + (d ? 2 * lat + 1 : lat);
    sbq.push_back(e);
    n_wb += d ? 1 : 0;
    n_fill++;
  endtask

  task automatic check_counts();
    chk("wb_count", 128'(wb_count), 128'(sat(n_wb, 65535)));
    chk("fill_count", 128'(fill_count), 128'(sat(n_fill, 65535)));
    chk("wb_count_sat4", 128'(wb_count2), 128'(sat(n_wb, 15)));
    chk("fill_count_sat4", 128'(fill_count2), 128'(sat(n_fill, 15)));
  endtask

  task automatic finish_miss();
    wait_idle();
    check_counts();
  endtask

  initial begin
    int c0, n;
    bit d;
    logic [31:0] ma, va;
    logic [127:0] vd;
    logic [127:0] beef = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    logic [127:0] a5 = {16{8'hA5}};
    for (int i = 0; i < 4096; i++) begin
      mem[i] = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[i] = mem[i];
    end
    mem[12'h123] = beef;
    ref_mem[12'h123] = beef;
    repeat (3) @(negedge clock);
    chk("rst_mem_req", 162'(mif.mem_req) == 162'd0 ? 128'd0 : 128'd1, 128'd0);
    chk("rst_fill_valid", 128'(fill_valid), 128'(0));
    chk("rst_fill_data", fill_data, 128'd0);
    chk("rst_timeout_err", 128'(timeout_err), 128'(0));
    check_counts();
    reset = 1'b1;
    @(negedge clock);
    chk("miss_ready_after_reset", 128'(miss_ready), 128'(1));

    lat = 7;
    start_miss(32'h0000_1234, 1'b0, 32'd0, 128'd0);
    @(negedge clock);
    chk("clean_req", 128'({mif.mem_req.valid, mif.mem_req.rw, mif.mem_req.addr}), 128'({1'b1, 1'b0, 32'h1230}));
    chk("clean_miss_ready_low", 128'(miss_ready), 128'(0));
    finish_miss();
    chk("clean_fill_held", fill_data, beef);

    start_miss(32'h0000_3000, 1'b1, 32'h0000_2040, a5);
    @(negedge clock);
    chk("wb_req", 128'({mif.mem_req.valid, mif.mem_req.rw, mif.mem_req.addr}), 128'({1'b1, 1'b1, 32'h2040}));
    chk("wb_data", mif.mem_req.data, a5);
    n = 0;
    while (mif.mem_req.valid && mif.mem_req.rw && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("wb_valid_cycles", 128'(n), 128'(lat));
    chk("gap_valid_low", 128'(mif.mem_req.valid), 128'(0));
    @(negedge clock);
    chk("refill_req", 128'({mif.mem_req.valid, mif.mem_req.rw, mif.mem_req.addr}), 128'({1'b1, 1'b0, 32'h3000}));
    finish_miss();
    chk("wb_mem_line", mem[12'h204], a5);

    lat = 4;
    issue(32'h0000_5670, 1'b0, 32'd0, 128'd0, c0);
    n = 0;
    @(negedge clock);
    #1;
    while (!mif.mem_data.ready && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("exc_ready_seen", 128'(mif.mem_data.ready), 128'(1));
    excpt_in = 3'b001;
    @(posedge clock);
    #1;
    excpt_in = 3'b000;
    @(negedge clock);
    chk("exc_miss_ready", 128'(miss_ready), 128'(1));
    chk("exc_valid_low", 128'(mif.mem_req.valid), 128'(0));
    check_counts();

    miss_addr = 32'h0000_7700; victim_dirty = 1'b0; miss_valid = 1'b1; excpt_in = 3'b010;
    @(posedge clock);
    #1;
    miss_valid = 1'b0; excpt_in = 3'b000;
    @(negedge clock);
    chk("exc_blocks_accept", 128'({mif.mem_req.valid, miss_ready}), 128'({1'b0, 1'b1}));

    hang = 1'b1;
    issue(32'h0000_4440, 1'b0, 32'd0, 128'd0, c0);
    n = 0;
    @(negedge clock);
    while (mif.mem_req.valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("timeout_valid_cycles", 128'(n), 128'(64));
    wait_idle();
    chk("timeout_err", 128'({timeout_err, timeout_err2}), 128'(2'b11));
    check_counts();
    hang = 1'b0;

    lat = 6;
    issue(32'h0000_6000, 1'b1, 32'h0000_6100, a5, c0);
    @(negedge clock);
    chk("pre_reset_wb_valid", 128'(mif.mem_req.valid), 128'(1));
    reset = 1'b0;
    #1;
    chk("async_rst_mem_req", (162'(mif.mem_req) | 162'(mif2.mem_req)) == 162'd0 ? 128'd0 : 128'd1, 128'd0);
    chk("async_rst_fill", 128'({fill_valid, fill_addr}), 128'd0);
    chk("async_rst_fill_data", fill_data, 128'd0);
    chk("async_rst_timeout_err", 128'({timeout_err, timeout_err2}), 128'd0);
    n_wb = 0;
    n_fill = 0;
    check_counts();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("miss_ready_after_rerelease", 128'({miss_ready, miss_ready2}), 128'(2'b11));
    start_miss(32'h0000_1234, 1'b0, 32'd0, 128'd0);
    finish_miss();

    repeat (40) begin
      lat = int'($urandom_range(1, 8));
      d = 1'($urandom);
      ma = $urandom;
      va = ($urandom_range(0, 3) == 0) ? ma ^ 32'h0000_0005 : $urandom;
      vd = {$urandom, $urandom, $urandom, $urandom};
      start_miss(ma, d, va, vd);
      finish_miss();
    end

    repeat (5) @(negedge clock);
    chk("scoreboard_drained", 128'(sbq.size()), 128'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks made", checks);
    $fatal(1);
  end
endmodule
